score_keeper: RTL and testbench

//  Consumes block_move's per-note judgement (add/wrong/down_target) and keeps game state.

---
 rtl/piano_defs.sv | 14 +
 rtl/bcd_inc4.sv | 33 +++
 rtl/score_keeper.sv | 150 +++++++++++++++
 tb/tb_score_keeper.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/piano_defs.sv
// Shared constants for the piano game datapath: FSM state encoding and BCD score limits.
package piano_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int          BCD_DIGIT_W = 4;
  localparam int          BCD_DIGITS  = 4;
  localparam logic [15:0] SCORE_MAX   = 16'h9999;

endpackage

// File: rtl/bcd_inc4.sv
// Four-digit BCD incrementer adding 1 or 2 with a ripple carry between digits.
// Any carry out of the top digit saturates the result at 9999.
module bcd_inc4
  import piano_defs::*;
(
  input  logic [15:0] i_value,
  input  logic        i_two,
  output logic [15:0] o_sum
);

  logic [BCD_DIGITS:1] w_carry;
  logic [15:0]         w_raw;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      logic [1:0] w_add;
      logic [4:0] w_tmp;
      if (gi == 0) begin : g_lsd
        assign w_add = i_two ? 2'd2 : 2'd1;
      end else begin : g_upper
        assign w_add = {1'b0, w_carry[gi]};
      end
      assign w_tmp = {1'b0, i_value[gi*BCD_DIGIT_W +: BCD_DIGIT_W]} + {3'b000, w_add};
      assign w_carry[gi+1] = (w_tmp > 5'd9);
      assign w_raw[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
        w_carry[gi+1] ? 4'(w_tmp - 5'd10) : w_tmp[3:0];
    end
  endgenerate

  assign o_sum = w_carry[BCD_DIGITS] ? SCORE_MAX : w_raw;

endmodule

// File: rtl/score_keeper.sv
// Game-state keeper between block_move and the display: judges one event per
// add/wrong window and tracks score, combo, lives and speed level.
module score_keeper
  import piano_defs::*;
#(
  parameter int LIVES       = 3,
  parameter int LEVEL_STEP  = 10,
  parameter int SLOW_INIT   = 4,
  parameter int SLOW_MIN    = 1,
  parameter int COMBO_BONUS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        add,
  input  logic        wrong,
  input  logic [3:0]  down_target,
  output logic        game_ena,
  output logic [2:0]  slow,
  output logic [15:0] score_bcd,
  output logic [7:0]  combo,
  output logic [7:0]  best_combo,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [3:0]  miss_key
);

  localparam int            HITS_W    = $clog2(LEVEL_STEP + 1);
  localparam logic [HITS_W-1:0] HITS_LAST = HITS_W'(LEVEL_STEP - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_enter_play;
  logic                r_start_q;
  logic                r_win_open;
  logic [HITS_W-1:0]   r_hits;
  logic [2:0]          r_slow;
  logic [15:0]         r_score;
  logic [7:0]          r_combo;
  logic [7:0]          r_best;
  logic [1:0]          r_lives;
  logic                r_hit_pulse;
  logic                r_miss_pulse;
  logic [3:0]          r_miss_key;

  logic                w_start_rise;
  logic                w_event;
  logic                w_hit;
  logic                w_miss;
  logic [7:0]          w_combo_inc;
  logic [15:0]         w_score_inc;

  assign w_start_rise = start_btn & ~r_start_q;
  assign w_event      = ~r_win_open & (add | wrong);
  // add wins when both flags open the window together
  assign w_hit        = (r_state == ST_PLAY) & w_event & add;
  assign w_miss       = (r_state == ST_PLAY) & w_event & ~add;
  assign w_combo_inc  = (r_combo == 8'hFF) ? 8'hFF : r_combo + 8'd1;

  bcd_inc4 u_bcd_inc4 (
    .i_value (r_score),
    .i_two   (r_combo >= 8'(COMBO_BONUS)),
    .o_sum   (w_score_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_enter_play = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_rise) begin
          w_state_next = ST_PLAY;
          w_enter_play = 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_miss && r_lives == 2'd1) w_state_next = ST_OVER;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Window tracking runs in every state so a flag held across PLAY entry is never judged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_q  <= 1'b1;
      r_win_open <= 1'b0;
    end else begin
      r_start_q  <= start_btn;
      r_win_open <= add | wrong;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits       <= '0;
      r_slow       <= 3'(SLOW_INIT);
      r_score      <= 16'h0000;
      r_combo      <= 8'd0;
      r_best       <= 8'd0;
      r_lives      <= 2'(LIVES);
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_miss_key   <= 4'd0;
    end else begin
      r_hit_pulse  <= w_hit;
      r_miss_pulse <= w_miss;
      if (w_enter_play) begin
        r_hits  <= '0;
        r_slow  <= 3'(SLOW_INIT);
        r_score <= 16'h0000;
        r_combo <= 8'd0;
        r_lives <= 2'(LIVES);
      end else if (w_hit) begin
        r_score <= w_score_inc;
        r_combo <= w_combo_inc;
        if (w_combo_inc > r_best) r_best <= w_combo_inc;
        if (r_hits == HITS_LAST) begin
          r_hits <= '0;
          if (r_slow > 3'(SLOW_MIN)) r_slow <= r_slow - 3'd1;
        end else begin
          r_hits <= r_hits + 1'b1;
        end
      end else if (w_miss) begin
        r_combo    <= 8'd0;
        r_lives    <= r_lives - 2'd1;
        r_miss_key <= down_target;
      end
    end
  end

  assign game_ena   = (r_state == ST_PLAY);
  assign game_over  = (r_state == ST_OVER);
  assign slow       = r_slow;
  assign score_bcd  = r_score;
  assign combo      = r_combo;
  assign best_combo = r_best;
  assign lives      = r_lives;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign miss_key   = r_miss_key;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: start, windows, bonus, level speed-up, game over, async reset.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b0;
  logic        add = 1'b0;
  logic        wrong = 1'b0;
  logic [3:0]  down_target = 4'd0;
  logic        game_ena;
  logic [2:0]  slow;
  logic [15:0] score_bcd;
  logic [7:0]  combo;
  logic [7:0]  best_combo;
  logic [1:0]  lives;
  logic        game_over;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [3:0]  miss_key;

  int n_checks = 0;
  int n_pass   = 0;
  int hit_cnt  = 0;
  int miss_cnt = 0;
  int h0;
  int m0;

  score_keeper dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .add         (add),
    .wrong       (wrong),
    .down_target (down_target),
    .game_ena    (game_ena),
    .slow        (slow),
    .score_bcd   (score_bcd),
    .combo       (combo),
    .best_combo  (best_combo),
    .lives       (lives),
    .game_over   (game_over),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .miss_key    (miss_key)
  );

  always #5 clk = ~clk;

  // A pulse is high for one full period, so each is seen on exactly one falling edge.
  always @(negedge clk) begin
    if (hit_pulse)  hit_cnt  <= hit_cnt + 1;
    if (miss_pulse) miss_cnt <= miss_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got %0h", tag, got);
    end else begin
      $display("FAIL %-14s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise flags on a falling edge and return just after the judging rising edge.
  task automatic raise(input logic a, input logic w, input logic [3:0] key);
    @(negedge clk);
    add = a;
    wrong = w;
    down_target = key;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_note(input int hi, input int lo);
    repeat (hi) @(negedge clk);
    add = 1'b0;
    wrong = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic note(input logic a, input logic w, input logic [3:0] key);
    raise(a, w, key);
    finish_note(4, 3);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_ena"},   32'(game_ena),   32'd0);
    check({pfx, "_slow"},  32'(slow),       32'd4);
    check({pfx, "_score"}, 32'(score_bcd),  32'h0000);
    check({pfx, "_combo"}, 32'(combo),      32'd0);
    check({pfx, "_best"},  32'(best_combo), 32'd0);
    check({pfx, "_lives"}, 32'(lives),      32'd3);
    check({pfx, "_over"},  32'(game_over),  32'd0);
    check({pfx, "_mkey"},  32'(miss_key),   32'd0);
  endtask

  initial begin
    int exp_slow;

    // Reset with start already held: releasing reset must not start a game.
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    check("rst_hitp", 32'(hit_pulse), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("held_start", 32'(game_ena), 32'd0);
    start_btn = 1'b0;
    pulse_start();
    check("start_ena",   32'(game_ena),  32'd1);
    check("start_lives", 32'(lives),     32'd3);
    check("start_slow",  32'(slow),      32'd4);
    check("start_score", 32'(score_bcd), 32'h0000);

    // Three clean add windows.
    h0 = hit_cnt;
    raise(1'b1, 1'b0, 4'd0);
    check("hit_pulse", 32'(hit_pulse), 32'd1);
    finish_note(5, 3);
    note(1'b1, 1'b0, 4'd0);
    note(1'b1, 1'b0, 4'd0);
    check("three_hits",  32'(hit_cnt - h0), 32'd3);
    check("score_3",     32'(score_bcd),    32'h0003);
    check("combo_3",     32'(combo),        32'd3);

    // Simultaneous rise is a hit; a late wrong inside an add window is ignored.
    m0 = miss_cnt;
    note(1'b1, 1'b1, 4'd2);
    raise(1'b1, 1'b0, 4'd0);
    repeat (2) @(negedge clk);
    wrong = 1'b1;
    finish_note(3, 3);
    check("no_miss",    32'(miss_cnt - m0), 32'd0);
    check("lives_kept", 32'(lives),         32'd3);
    check("five_hits",  32'(hit_cnt - h0),  32'd5);
    check("score_5",    32'(score_bcd),     32'h0005);

    // Asynchronous reset mid-game, observed before any clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_btn = 1'b0;
    pulse_start();
    start_btn = 1'b0;
    check("restart_ena", 32'(game_ena), 32'd1);

    // Six hits: sixth hit sees combo 5 and scores +2.
    for (int i = 0; i < 6; i++) note(1'b1, 1'b0, 4'd0);
    check("score_7", 32'(score_bcd),  32'h0007);
    check("combo_6", 32'(combo),      32'd6);
    check("best_6",  32'(best_combo), 32'd6);
    m0 = miss_cnt;
    raise(1'b0, 1'b1, 4'd9);
    check("miss_pulse", 32'(miss_pulse), 32'd1);
    finish_note(4, 3);
    check("miss_combo", 32'(combo),          32'd0);
    check("miss_best",  32'(best_combo),     32'd6);
    check("miss_lives", 32'(lives),          32'd2);
    check("miss_key9",  32'(miss_key),       32'd9);
    check("one_miss",   32'(miss_cnt - m0),  32'd1);

    // Run out of lives.
    note(1'b0, 1'b1, 4'd3);
    check("lives_1", 32'(lives), 32'd1);
    raise(1'b0, 1'b1, 4'd5);
    check("over_flag",  32'(game_over), 32'd1);
    check("over_ena",   32'(game_ena),  32'd0);
    check("over_lives", 32'(lives),     32'd0);
    check("over_key",   32'(miss_key),  32'd5);
    finish_note(4, 3);
    h0 = hit_cnt;
    note(1'b1, 1'b0, 4'd0);
    check("over_nohit", 32'(hit_cnt - h0), 32'd0);
    check("over_score", 32'(score_bcd),    32'h0007);
    pulse_start();
    start_btn = 1'b0;
    check("replay_ena",   32'(game_ena),   32'd1);
    check("replay_score", 32'(score_bcd),  32'h0000);
    check("replay_best",  32'(best_combo), 32'd6);
    check("replay_lives", 32'(lives),      32'd3);
    check("replay_over",  32'(game_over),  32'd0);

    // Level speed-up every 10 hits, floored at 1.
    for (int n = 1; n <= 40; n++) begin
      raise(1'b1, 1'b0, 4'd0);
      if (n == 9 || n == 10 || n == 19 || n == 20 || n == 29 || n == 30 || n == 31 || n == 40) begin
        exp_slow = (n / 10 >= 3) ? 1 : 4 - n / 10;
        check($sformatf("slow_hit%0d", n), 32'(slow), 32'(exp_slow));
      end
      finish_note(3, 2);
    end
    check("score_75", 32'(score_bcd),  32'h0075);
    check("combo_40", 32'(combo),      32'd40);
    check("best_40",  32'(best_combo), 32'd40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
